// File: rtl/mux_n_reg.sv
// N-channel registered multiplexer with direct-select and round-robin scan modes.
// Out-of-range indices produce zero data and raise a sticky-until-next-capture error flag.

module mux_n_reg_lane #(
    parameter int W  = 8,
    parameter int SW = 2,
    parameter int K  = 0
) (
    input  logic [W-1:0]  d,
    input  logic [SW-1:0] idx,
    output logic [W-1:0]  q
);
    assign q = (idx == SW'(K)) ? d : '0;
endmodule

module mux_n_reg #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] D,
    input  logic [SW-1:0]  S,
    input  logic           mode,
    input  logic           en,
    input  logic           load,
    output logic [W-1:0]   Y,
    output logic           Y_valid,
    output logic [SW-1:0]  cur_sel,
    output logic           sel_err
);
    localparam logic [SW:0]   NUM  = (SW+1)'(N);
    localparam logic [SW-1:0] LAST = SW'(N-1);

    logic [SW-1:0]           p;
    logic [SW-1:0]           idx;
    logic [SW-1:0]           nxt;
    logic                    oor;
    logic [N-1:0][W-1:0]     lane_q;
    logic [W-1:0]            sel_data;

    // load overrides the scan pointer for this capture; direct mode always uses S
    assign idx = (mode && !load) ? p : S;
    assign oor = ({1'b0, idx} >= NUM);
    assign nxt = (oor || idx == LAST) ? '0 : idx + 1'b1;

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_lane
            mux_n_reg_lane #(.W(W), .SW(SW), .K(k)) u_lane (
                .d   (D[k*W +: W]),
                .idx (idx),
                .q   (lane_q[k])
            );
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++)
            sel_data = sel_data | lane_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Y       <= '0;
            Y_valid <= 1'b0;
            cur_sel <= '0;
            sel_err <= 1'b0;
            p       <= '0;
        end else if (en) begin
            Y       <= oor ? '0 : sel_data;
            Y_valid <= 1'b1;
            cur_sel <= idx;
            sel_err <= oor;
            if (mode)
                p <= nxt;
        end else begin
            Y_valid <= 1'b0;
            if (mode && load)
                p <= S;
        end
    end
endmodule

// File: tb/tb_mux_n_reg.sv
// Scoreboard bench: stimulus pushes expected outputs, per-DUT monitors pop and compare.
// Two instances cover N=4 (power of two) and N=3 (out-of-range select reachable).

module tb_mux_n_reg;
    typedef struct {
        logic [7:0] y;
        logic       v;
        logic [1:0] sel;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode = 1'b0;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;
    logic        load = 1'b0;
    logic [1:0]  s = '0;
    logic [31:0] d_a = 32'h44332211;
    logic [23:0] d_b = 24'hCCBBAA;

    logic [7:0]  y_a, y_b;
    logic        v_a, v_b;
    logic [1:0]  sel_a, sel_b;
    logic        err_a, err_b;

    exp_t qa[$];
    exp_t qb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mux_n_reg #(.W(8), .N(4), .SW(2)) u_dut_a (
        .clk(clk), .rst(rst), .D(d_a), .S(s), .mode(mode), .en(en_a), .load(load),
        .Y(y_a), .Y_valid(v_a), .cur_sel(sel_a), .sel_err(err_a)
    );

    mux_n_reg #(.W(8), .N(3), .SW(2)) u_dut_b (
        .clk(clk), .rst(rst), .D(d_b), .S(s), .mode(mode), .en(en_b), .load(load),
        .Y(y_b), .Y_valid(v_b), .cur_sel(sel_b), .sel_err(err_b)
    );

    task automatic step(input logic r, input logic m, input logic ea, input logic eb,
                        input logic ld, input logic [1:0] sv);
        @(negedge clk);
        #1;
        rst = r; mode = m; en_a = ea; en_b = eb; load = ld; s = sv;
    endtask

    task automatic expa(input logic [7:0] y, input logic v, input logic [1:0] sel, input logic err);
        exp_t e;
        e.y = y; e.v = v; e.sel = sel; e.err = err;
        qa.push_back(e);
    endtask

    task automatic expb(input logic [7:0] y, input logic v, input logic [1:0] sel, input logic err);
        exp_t e;
        e.y = y; e.v = v; e.sel = sel; e.err = err;
        qb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            n_chk++;
            if (y_a !== e.y || v_a !== e.v || sel_a !== e.sel || err_a !== e.err) begin
                n_fail++;
                $display("FAIL dut_a #%0d: got Y=%h V=%b sel=%0d err=%b, want Y=%h V=%b sel=%0d err=%b",
                         n_chk, y_a, v_a, sel_a, err_a, e.y, e.v, e.sel, e.err);
            end
        end else if (v_a === 1'b1) begin
            n_chk++; n_fail++;
            $display("FAIL dut_a unexpected_valid: got Y=%h sel=%0d, want no output", y_a, sel_a);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (qb.size() > 0) begin
            e = qb.pop_front();
            n_chk++;
            if (y_b !== e.y || v_b !== e.v || sel_b !== e.sel || err_b !== e.err) begin
                n_fail++;
                $display("FAIL dut_b #%0d: got Y=%h V=%b sel=%0d err=%b, want Y=%h V=%b sel=%0d err=%b",
                         n_chk, y_b, v_b, sel_b, err_b, e.y, e.v, e.sel, e.err);
            end
        end else if (v_b === 1'b1) begin
            n_chk++; n_fail++;
            $display("FAIL dut_b unexpected_valid: got Y=%h sel=%0d, want no output", y_b, sel_b);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state on both instances
        step(1, 0, 0, 0, 0, 0); expa(8'h00, 0, 0, 0); expb(8'h00, 0, 0, 0);
        // direct select, then hold with en low
        step(0, 0, 1, 0, 0, 2); expa(8'h33, 1, 2, 0);
        step(0, 0, 0, 0, 0, 2); expa(8'h33, 0, 2, 0);
        // scan from reset: six captures wrap 0..3,0,1
        step(1, 1, 0, 0, 0, 0); expa(8'h00, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0); expa(8'h11, 1, 0, 0);
        step(0, 1, 1, 0, 0, 0); expa(8'h22, 1, 1, 0);
        step(0, 1, 1, 0, 0, 0); expa(8'h33, 1, 2, 0);
        step(0, 1, 1, 0, 0, 0); expa(8'h44, 1, 3, 0);
        step(0, 1, 1, 0, 0, 0); expa(8'h11, 1, 0, 0);
        step(0, 1, 1, 0, 0, 0); expa(8'h22, 1, 1, 0);
        // load with en: P=1, force S=3 then continue from 0
        step(1, 1, 0, 0, 0, 0); expa(8'h00, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0); expa(8'h11, 1, 0, 0);
        step(0, 1, 1, 0, 1, 3); expa(8'h44, 1, 3, 0);
        step(0, 1, 1, 0, 0, 0); expa(8'h11, 1, 0, 0);
        // en toggling 1,0,1 from P=1
        step(0, 1, 1, 0, 0, 0); expa(8'h22, 1, 1, 0);
        step(0, 1, 0, 0, 0, 0); expa(8'h22, 0, 1, 0);
        step(0, 1, 1, 0, 0, 0); expa(8'h33, 1, 2, 0);
        // direct mode ignores load and holds P=3; re-entering scan resumes at 3
        step(0, 0, 1, 0, 1, 0); expa(8'h11, 1, 0, 0);
        step(0, 1, 1, 0, 0, 1); expa(8'h44, 1, 3, 0);
        // load without en: P<=S, no capture
        step(0, 1, 0, 0, 1, 2); expa(8'h44, 0, 3, 0);
        step(0, 1, 1, 0, 0, 0); expa(8'h33, 1, 2, 0);
        // rst beats en/load mid-scan at P=2
        step(0, 1, 0, 0, 1, 2); expa(8'h33, 0, 2, 0);
        step(1, 1, 1, 0, 1, 3); expa(8'h00, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0); expa(8'h11, 1, 0, 0);

        // N=3 instance: out-of-range direct select, hold, recover
        step(0, 0, 0, 1, 0, 3); expb(8'h00, 1, 3, 1);
        step(0, 0, 0, 0, 0, 3); expb(8'h00, 0, 3, 1);
        step(0, 0, 0, 1, 0, 1); expb(8'hBB, 1, 1, 0);
        // scan pointer loaded out of range: zero output, then P restarts at 0 and wraps at 2
        step(0, 1, 0, 0, 1, 3); expb(8'hBB, 0, 1, 0);
        step(0, 1, 0, 1, 0, 0); expb(8'h00, 1, 3, 1);
        step(0, 1, 0, 1, 0, 0); expb(8'hAA, 1, 0, 0);
        step(0, 1, 0, 1, 0, 0); expb(8'hBB, 1, 1, 0);
        step(0, 1, 0, 1, 0, 0); expb(8'hCC, 1, 2, 0);
        step(0, 1, 0, 1, 0, 0); expb(8'hAA, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0); expb(8'hAA, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", qa.size(), qb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
